// File: rtl/xor_inv_arbiter.sv
// Shares one XOR/invert unit (C = A^B, inverted when A[7]=1) between NUM_REQ round-robin requesters.
// Latency: request handshake at edge t -> rsp_valid seen at edge t+2; 3 cycles minimum per op, no overlap.
// Backpressure: rsp_valid/data/id held until rsp_ready; req_ready stays low outside IDLE.
module xor_inv_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_a,
    input  logic [NUM_REQ*8-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [7:0]           rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy,
    output logic [15:0]          done_cnt
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [7:0]      a;
        logic [7:0]      b;
        logic [ID_W-1:0] id;
    } op_t;

    state_t          state;
    state_t          state_nxt;
    op_t             op;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] rr_ptr_nxt;
    logic            gnt_vld;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W:0]   cand;
    logic [7:0]      a_arr [NUM_REQ];
    logic [7:0]      b_arr [NUM_REQ];

    function automatic logic [7:0] custom_logic(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x;
        x = a ^ b;
        return a[7] ? ~x : x;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i] = req_a[i*8 +: 8];
            b_arr[i] = req_b[i*8 +: 8];
        end
    end

    // Cyclic first-valid search starting at rr_ptr; cand wraps modulo NUM_REQ.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!gnt_vld && req_valid[cand[ID_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && gnt_vld) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign busy       = (state != IDLE);
    assign rr_ptr_nxt = (op.id == ID_W'(NUM_REQ-1)) ? '0 : op.id + ID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_vld) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            done_cnt  <= '0;
            op        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        op.a  <= a_arr[gnt_idx];
                        op.b  <= b_arr[gnt_idx];
                        op.id <= gnt_idx;
                    end
                end
                EXEC: begin
                    rsp_data  <= custom_logic(op.a, op.b);
                    rsp_id    <= op.id;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= rr_ptr_nxt;
                        done_cnt  <= done_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_inv_arbiter.sv
// Directed and randomised checks of xor_inv_arbiter: grant order, latency, backpressure, reset abort.
module tb_xor_inv_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_a;
    logic [N*8-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [7:0]     rsp_data;
    logic [1:0]     rsp_id;
    logic           busy;
    logic [15:0]    done_cnt;

    int tests    = 0;
    int errors   = 0;
    int cyc      = 0;
    int exp_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xor_inv_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_c(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x;
        x = a ^ b;
        return a[7] ? ~x : x;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_done = 0;
        #1;
    endtask

    // Single-requester operation starting at a negedge with the DUT idle.
    task automatic do_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_c, input int stall, input string tag);
        req_a            = $urandom;
        req_b            = $urandom;
        req_a[idx*8 +: 8] = a;
        req_b[idx*8 +: 8] = b;
        req_valid        = '0;
        req_valid[idx]   = 1'b1;
        rsp_ready        = 1'b0;
        #1;
        check({tag, ".req_ready"}, req_ready, 32'(1 << idx));
        @(negedge clk);
        req_valid = '0;
        #1;
        check({tag, ".exec_busy"}, busy, 1);
        check({tag, ".exec_vld"}, rsp_valid, 0);
        @(negedge clk);
        check({tag, ".rsp_vld"}, rsp_valid, 1);
        check({tag, ".rsp_data"}, rsp_data, exp_c);
        check({tag, ".rsp_id"}, rsp_id, idx);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({tag, ".stall_data"}, rsp_data, exp_c);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        exp_done++;
        #1;
        check({tag, ".done_vld"}, rsp_valid, 0);
        check({tag, ".done_busy"}, busy, 0);
        check({tag, ".done_cnt"}, done_cnt, exp_done & 16'hFFFF);
        rsp_ready = 1'b0;
    endtask

    task automatic rr_test();
        int w;
        int last;
        last = 0;
        for (int n = 0; n < 5; n++) begin
            w = 0;
            while (!(busy == 1'b0 && req_ready != '0) && w < 8) begin
                @(negedge clk);
                #1;
                w++;
            end
            check($sformatf("rr.grant%0d", n), req_ready, 32'(1 << (n % N)));
            if (n > 0) check($sformatf("rr.gap%0d", n), cyc - last, 3);
            last = cyc;
            @(negedge clk);
            #1;
        end
        req_valid = '0;
        repeat (2) @(negedge clk);
        exp_done = 5;
        #1;
        check("rr.done_cnt", done_cnt, exp_done);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        do_reset();
        check("rst.rsp_valid", rsp_valid, 0);
        check("rst.busy", busy, 0);
        check("rst.done_cnt", done_cnt, 0);
        check("rst.rsp_data", rsp_data, 0);
        check("rst.rsp_id", rsp_id, 0);
        check("rst.req_ready", req_ready, 0);

        do_op(0, 8'h0F, 8'hF0, 8'hFF, 0, "t1");
        do_op(2, 8'h8F, 8'h0F, 8'h7F, 0, "t2");

        // rsp_ready with no response pending must not count
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("idle_ready.done_cnt", done_cnt, exp_done);
        check("idle_ready.rsp_valid", rsp_valid, 0);
        rsp_ready = 1'b0;

        // all requesters held valid from reset
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        do_reset();
        rr_test();
        rsp_ready = 1'b0;

        // backpressure in RESP; request arriving with the handshake waits a cycle
        req_a[15:8] = 8'h12;
        req_b[15:8] = 8'h34;
        req_valid   = 4'b0010;
        #1;
        check("bp.req_ready", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        check("bp.exec_ready", req_ready, 0);
        @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            #1;
            check($sformatf("bp.vld%0d", s), rsp_valid, 1);
            check($sformatf("bp.data%0d", s), rsp_data, 8'h26);
            check($sformatf("bp.id%0d", s), rsp_id, 1);
            check($sformatf("bp.ready%0d", s), req_ready, 0);
            check($sformatf("bp.busy%0d", s), busy, 1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp.hs_ready", req_ready, 0);
        @(negedge clk);
        exp_done++;
        #1;
        check("bp.done_cnt", done_cnt, exp_done);
        check("bp.rsp_valid", rsp_valid, 0);
        check("bp.next_grant", req_ready, 4'b0100);
        req_valid = '0;
        rsp_ready = 1'b0;

        // reset during EXEC aborts the operation
        req_a[31:24] = 8'h55;
        req_b[31:24] = 8'hAA;
        req_valid    = 4'b1000;
        #1;
        check("abort.req_ready", req_ready, 4'b1000);
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        exp_done = 0;
        #1;
        check("abort.rsp_valid", rsp_valid, 0);
        check("abort.busy", busy, 0);
        check("abort.done_cnt", done_cnt, 0);
        req_valid = 4'b1111;
        #1;
        check("abort.rr_ptr", req_ready, 4'b0001);
        req_valid = '0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check($sformatf("abort.no_rsp%0d", s), rsp_valid, 0);
        end
        rsp_ready = 1'b0;

        // randomised scoreboard
        for (int k = 0; k < 150; k++) begin
            logic [7:0] a;
            logic [7:0] b;
            int         idx;
            a   = 8'($urandom);
            b   = 8'($urandom);
            idx = $urandom_range(0, N-1);
            do_op(idx, a, b, ref_c(a, b), $urandom_range(0, 2), $sformatf("rnd%0d", k));
        end
        check("rnd.total", done_cnt, 150);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
